// File: rtl/corr_pkg.sv
// Shared types and width helpers for the correlation peak timer.
package corr_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  function automatic int corr_sw(input int dw, input int len);
    return dw + $clog2(len) + 1;
  endfunction

  function automatic int corr_mid(input int dw);
    return 2 ** (dw - 1);
  endfunction

  localparam int DW_DEF = 8;
  localparam int MID    = corr_mid(DW_DEF);

endpackage

// File: rtl/corr_mac.sv
// Sample history and +/-1 code correlator; corr and its valid land one clk after
// the strobe edge that shifted the sample in.
module corr_mac
  import corr_pkg::*;
#(
  parameter int             DW   = 8,
  parameter int             LEN  = 16,
  parameter logic [LEN-1:0] CODE = 16'hE2B4,
  parameter int             SW   = corr_sw(DW, LEN)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ena,
  input  logic [DW-1:0]        i_in,
  output logic signed [SW-1:0] o_corr,
  output logic                 o_corr_v
);

  localparam logic signed [DW:0] MID_S = (DW + 1)'(corr_mid(DW));

  logic signed [DW:0]   w_s;
  logic signed [DW:0]   r_hist_p0 [LEN];
  logic                 r_vld_p0;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] r_corr_p1;
  logic                 r_vld_p1;

  assign w_s = $signed({1'b0, i_in}) - MID_S;

  // stage p0: history shift, index 0 is the newest sample
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_p0 <= 1'b0;
      for (int k = 0; k < LEN; k++) r_hist_p0[k] <= '0;
    end else begin
      r_vld_p0 <= i_ena;
      if (i_ena) begin
        r_hist_p0[0] <= w_s;
        for (int k = 1; k < LEN; k++) r_hist_p0[k] <= r_hist_p0[k-1];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LEN; k++) begin
      if (CODE[k]) w_sum = w_sum + SW'(r_hist_p0[k]);
      else         w_sum = w_sum - SW'(r_hist_p0[k]);
    end
  end

  // stage p1: registered correlation
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_p1  <= 1'b0;
      r_corr_p1 <= '0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) r_corr_p1 <= w_sum;
    end
  end

  assign o_corr   = r_corr_p1;
  assign o_corr_v = r_vld_p1;

endmodule

// File: rtl/corr_peak_timer.sv
// Windowed peak search over the correlator output with a ready/ack result
// handshake, timeout reporting and optional automatic re-arm.
module corr_peak_timer
  import corr_pkg::*;
#(
  parameter int             DW     = 8,
  parameter int             LEN    = 16,
  parameter logic [LEN-1:0] CODE   = 16'hE2B4,
  parameter int             TW     = 14,
  parameter int             WINDOW = 10000,
  parameter int             CONT   = 0,
  parameter int             SW     = corr_sw(DW, LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [DW-1:0]        in,
  input  logic                 arm,
  input  logic                 ack,
  input  logic signed [SW-1:0] thr,
  output logic [TW-1:0]        tim,
  output logic signed [SW-1:0] peak,
  output logic                 rdy,
  output logic                 timeout,
  output logic                 busy
);

  localparam logic [TW-1:0] LAST_IDX = TW'(WINDOW - 1);

  logic signed [SW-1:0] w_corr;
  logic                 w_vld;
  logic                 w_upd;
  logic                 w_last;

  state_t               r_state;
  logic [TW-1:0]        r_idx;
  logic                 r_have;
  logic signed [SW-1:0] r_best;
  logic [TW-1:0]        r_btim;
  logic [TW-1:0]        r_tim;
  logic signed [SW-1:0] r_peak;
  logic                 r_rdy;
  logic                 r_to;
  logic                 r_busy;

  corr_mac #(
    .DW  (DW),
    .LEN (LEN),
    .CODE(CODE),
    .SW  (SW)
  ) u_mac (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_ena   (ena),
    .i_in    (in),
    .o_corr  (w_corr),
    .o_corr_v(w_vld)
  );

  // strict compares: equal-to-threshold never detects, ties keep the earliest peak
  assign w_upd  = w_vld && (w_corr > thr) && (!r_have || (w_corr > r_best));
  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_have  <= 1'b0;
      r_best  <= '0;
      r_btim  <= '0;
      r_tim   <= '0;
      r_peak  <= '0;
      r_rdy   <= 1'b0;
      r_to    <= 1'b0;
      r_busy  <= 1'b0;
    end else if (arm) begin
      r_state <= SEARCH;
      r_busy  <= 1'b1;
      r_idx   <= '0;
      r_have  <= 1'b0;
      r_best  <= '0;
      r_btim  <= '0;
      r_rdy   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_busy <= 1'b0;
        SEARCH: begin
          if (w_vld) begin
            if (w_upd) begin
              r_have <= 1'b1;
              r_best <= w_corr;
              r_btim <= r_idx;
            end
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              if (w_upd || r_have) begin
                r_rdy  <= 1'b1;
                r_tim  <= w_upd ? r_idx : r_btim;
                r_peak <= w_upd ? w_corr : r_best;
              end else begin
                r_to <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + TW'(1);
            end
          end
        end
        DONE: begin
          if (ack) begin
            r_rdy <= 1'b0;
            r_to  <= 1'b0;
            if (CONT != 0) begin
              r_state <= SEARCH;
              r_busy  <= 1'b1;
              r_idx   <= '0;
              r_have  <= 1'b0;
              r_best  <= '0;
              r_btim  <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tim     = r_tim;
  assign peak    = r_peak;
  assign rdy     = r_rdy;
  assign timeout = r_to;
  assign busy    = r_busy;

endmodule

// File: doc/corr_peak_timer.md
Name: corr_peak_timer

Overview:
- Parametrised successor of the fixed correlator core that feeds the soft-processor PIO with {rdy, tim}.
- Computes a sliding correlation of the received sample stream against a compile-time ±1 code.
- Searches a programmable window after an arm command and reports the time index and magnitude of the largest above-threshold peak.
- Holds the result under a ready/ack handshake toward the processor; adds timeout reporting and a continuous (auto re-arm) mode.

Parameters:
- DW, 8: input sample width; offset-binary unsigned.
- LEN, 16: code length / correlation taps (2..64).
- CODE, 16'hE2B4: LEN-bit code; bit k=1 weights s[n-k] by +1, bit k=0 by -1 (k=0 is the newest sample).
- TW, 14: timestamp width.
- WINDOW, 10000: samples searched per arm; 1 ≤ WINDOW ≤ 2^TW-1.
- CONT, 0: 1 = auto re-arm after ack.
- SW, DW+$clog2(LEN)+1: derived correlation width, signed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ena  in  1  sample strobe; in is valid when 1
- in  in  DW  received sample
- arm  in  1  single-cycle pulse: start a search
- ack  in  1  single-cycle pulse: processor consumed the result
- thr  in  SW  signed detection threshold, sampled each compare
- tim  out  TW  sample index of the best peak
- peak  out  SW  signed correlation value at the best peak
- rdy  out  1  result valid
- timeout  out  1  window ended with no sample above thr
- busy  out  1  search in progress

Behaviour:
- Reset:
  - History registers hold signed 0 (input 2^(DW-1)); corr register is 0.
  - State IDLE; tim=0, peak=0, rdy=0, timeout=0, busy=0.
  - Reset is asynchronous and may occur mid-search; it aborts the search with no result.
- Sample path:
  - s = in - 2^(DW-1), signed DW+1.
  - On each ena, s shifts into a LEN-deep history, independent of state.
  - corr = Σ ±s[n-k] in SW bits, registered with corr_v one clk after the ena edge. No overflow is possible at SW.
- Sample counter idx (TW bits):
  - Cleared by arm.
  - Increments on each corr_v while in SEARCH; the first corr after arm has idx 0.
  - Its range is bounded by WINDOW, so no wrap.
- FSM:
  - IDLE: busy=0. arm → SEARCH, clearing best, idx, rdy and timeout.
  - SEARCH: busy=1. On each corr_v:
    - If corr > thr and (no best yet, or corr > best), store best=corr and btim=idx.
    - Ties keep the earliest peak (strict >).
    - When this corr_v is the WINDOW-th: go to DONE. If a best exists, tim=btim, peak=best, rdy=1; otherwise timeout=1 (tim and peak hold their previous values).
  - DONE: busy=0, rdy or timeout held.
    - ack → clears rdy and timeout.
    - Then IDLE (CONT=0), or SEARCH with idx cleared (CONT=1).
- Latency: rdy or timeout rises on the edge 2 clk after the edge that accepted the WINDOW-th counted sample.
- Boundary cases:
  - arm during SEARCH: restart; best and idx cleared.
  - arm in DONE: acts as ack followed by a restart.
  - ack outside DONE: ignored.
  - ack and arm in the same cycle: arm wins.
  - ena and arm in the same cycle: the sample enters history; corr_v for it is counted as idx 0.
  - Partially filled history after reset correlates against zeros; this is not masked.
  - Samples arriving in DONE update history but are not counted.

Decomposition:
- Package corr_pkg holds:
  - the state enum (IDLE, SEARCH, DONE);
  - a function computing SW from DW and LEN;
  - the localparam MID = 2^(DW-1).
- Sub-module corr_mac (shift history plus ±1 adder tree with registered corr and corr_v) is natural and independently testable.
- The top level contains the FSM, counter and result registers.

Test Plan:
- Config: DW=8, LEN=4, CODE=4'b1101, WINDOW=16, TW=14, CONT=0, thr=200, idle input 128.
- Single peak: arm, then feed 128×5, 228, 228, 28, 228, then 128×7 → rdy=1, tim=8, peak=400, timeout=0, busy=0. A single ack clears rdy; state is IDLE.
- No detection: arm, 16 samples of 128 → timeout=1, rdy=0, tim and peak unchanged. ack → timeout=0.
- Tie and ordering: feed the same 4-sample pattern completing at idx 4 and again at idx 12 → tim=4, peak=400 (earliest kept). Repeat with the second copy scaled (using 248/8) → tim=12, peak=480.
- Threshold equal: pattern giving corr exactly 200 (178,178,78,178) with thr=200 → timeout=1. Set thr=199 → rdy=1, peak=200.
- Restart and reset: arm, 10 samples, arm again → a pattern at the original idx 12 is reported as idx 2 of the new count. Asserting rst mid-search → all outputs 0 immediately, without waiting for clk.
- Continuous mode: CONT=1, two windows each containing a pattern → rdy after each; ack re-arms, busy=1 the next cycle. A sample fed while in DONE does not advance idx.
